// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE   = 2'd0,
    IMEM_ACCESS = 2'd1,
    IMEM_RESP   = 2'd2
  } imem_state_t;

  // Instruction returned alongside an access fault (RISC-V addi x0,x0,0).
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Select the 32-bit instruction slot out of a 64-bit line.
  function automatic logic [31:0] pick_half(input logic [63:0] line, input logic upper);
    return upper ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/imem_array.sv
// Backing store: one synchronous write port, combinational read port.
// A read of the word being written this cycle returns the new data.
module imem_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [63:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [63:0]           rdata
);

  logic [63:0] mem [1 << DEPTH_LOG2];

  // Loader write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fetch-port responder: decode, fault check, one-line buffer and a
// fixed-latency miss path into the backing array.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter int          MEM_LATENCY = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ena,
  input  logic [63:0]           inst_addr,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  inst_err,
  output logic                  busy,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [63:0]           ld_data
);

  localparam logic [3:0]  LAT_INIT = 4'(MEM_LATENCY - 1);
  localparam logic [63:0] SPAN     = 64'd8 << DEPTH_LOG2;

  imem_state_t           state, nxt;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx, cap_idx, lb_tag;
  logic                  half, cap_half, lb_valid;
  logic                  fault, hit, accept, fill;
  logic [63:0]           off, lb_data, rd_data;

  // Address decode; wrap-around below BASE_ADDR lands far out of range.
  assign off   = inst_addr - BASE_ADDR;
  assign idx   = off[DEPTH_LOG2+2:3];
  assign half  = off[2];
  assign fault = (inst_addr[1:0] != 2'b00) || (off >= SPAN);
  // A loader write to the hit line this cycle makes the buffered copy stale.
  assign hit   = lb_valid && (lb_tag == idx) && !(ld_we && (ld_addr == idx));

  imem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (ld_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (cap_idx),
    .rdata (rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IMEM_IDLE;
    else     state <= nxt;
  end

  // Next state and per-state strobes; RESP accepts a new request back-to-back.
  always_comb begin
    nxt        = state;
    accept     = 1'b0;
    fill       = 1'b0;
    busy       = 1'b0;
    inst_valid = 1'b0;
    case (state)
      IMEM_IDLE, IMEM_RESP: begin
        inst_valid = (state == IMEM_RESP);
        nxt        = IMEM_IDLE;
        if (inst_ena) begin
          accept = 1'b1;
          nxt    = (fault || hit) ? IMEM_RESP : IMEM_ACCESS;
        end
      end
      IMEM_ACCESS: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          fill = 1'b1;
          nxt  = IMEM_RESP;
        end
      end
      default: nxt = IMEM_IDLE;
    endcase
  end

  // Request capture, latency counter, response registers and line buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst     <= '0;
      inst_err <= 1'b0;
      cnt      <= '0;
      cap_idx  <= '0;
      cap_half <= 1'b0;
      lb_valid <= 1'b0;
      lb_tag   <= '0;
      lb_data  <= '0;
    end else begin
      if (accept) begin
        cap_idx  <= idx;
        cap_half <= half;
        cnt      <= LAT_INIT;
        if (fault) begin
          inst     <= INST_NOP;
          inst_err <= 1'b1;
        end else if (hit) begin
          inst     <= pick_half(lb_data, half);
          inst_err <= 1'b0;
        end
      end else if (busy && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      // Fill wins over invalidation so a same-index loader write stays cached.
      if (fill) begin
        inst     <= pick_half(rd_data, cap_half);
        inst_err <= 1'b0;
        lb_valid <= 1'b1;
        lb_tag   <= cap_idx;
        lb_data  <= rd_data;
      end else if (ld_we && (ld_addr == lb_tag)) begin
        lb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed scenarios then random traffic.
module tb_imem_responder;

  localparam int          DL   = 12;
  localparam int          LAT  = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] NOP  = 64'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, inst_ena, ld_we;
  logic [63:0]   inst_addr, ld_data;
  logic [DL-1:0] ld_addr;
  logic [31:0]   inst;
  logic          inst_valid, inst_err, busy;

  imem_responder #(.DEPTH_LOG2(DL), .MEM_LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .inst_ena(inst_ena), .inst_addr(inst_addr),
    .inst(inst), .inst_valid(inst_valid), .inst_err(inst_err), .busy(busy),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t me;

  // Reference model: memory image, cached line, and remaining miss cycles.
  logic [63:0]   mmem [1 << DL];
  logic          m_lbv  = 1'b0;
  int            m_tag  = 0;
  logic [63:0]   m_data = '0;
  int            acc_left = 0;
  int            p_idx = 0;
  logic          p_half = 1'b0;

  function automatic logic [31:0] half32(input logic [63:0] w, input logic up);
    return up ? w[63:32] : w[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic e);
    exp_t x;
    x.inst = i; x.err = e; x.due = cyc + 1;
    q.push_back(x);
  endtask

  // Drive one cycle of inputs, advance the model over the coming edge, then
  // wait for the following falling edge.
  task automatic step(input logic r, input logic e, input logic [63:0] a,
                      input logic w, input logic [DL-1:0] la, input logic [63:0] ld);
    logic [63:0] off;
    logic        flt;
    int          idx;
    logic        hf;
    if (cyc > 0) chk("busy", busy, (acc_left > 0));
    rst = r; inst_ena = e; inst_addr = a; ld_we = w; ld_addr = la; ld_data = ld;
    off = a - BASE;
    flt = (a[1:0] != 2'b00) || (off >= 64'(8 << DL));
    idx = int'(off >> 3);
    hf  = off[2];
    if (r) begin
      if (w) mmem[la] = ld;
      acc_left = 0;
      m_lbv = 1'b0;
    end else if (acc_left > 0) begin
      if (w) mmem[la] = ld;
      if (acc_left == 1) begin
        m_lbv = 1'b1; m_tag = p_idx; m_data = mmem[p_idx];
        push(half32(m_data, p_half), 1'b0);
      end else if (w && int'(la) == m_tag) begin
        m_lbv = 1'b0;
      end
      acc_left--;
    end else begin
      if (e) begin
        if (flt) push(NOP[31:0], 1'b1);
        else if (m_lbv && m_tag == idx && !(w && int'(la) == idx)) push(half32(m_data, hf), 1'b0);
        else begin acc_left = LAT; p_idx = idx; p_half = hf; end
      end
      if (w) begin
        mmem[la] = ld;
        if (int'(la) == m_tag) m_lbv = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'h0, 1'b0, '0, 64'h0);
  endtask

  task automatic fetch(input logic [63:0] a);
    step(1'b0, 1'b1, a, 1'b0, '0, 64'h0);
  endtask

  function automatic logic [63:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3, 4, 5: return BASE + 64'($urandom_range(0, 31)) * 64'd4;
      6: return BASE + 64'($urandom_range(0, 127));
      7: return BASE - 64'($urandom_range(1, 16)) * 64'd4;
      8: return ($urandom_range(0, 1) != 0) ? BASE + 64'(8 << DL) - 64'd4 : BASE + 64'(8 << DL);
      default: return {$urandom, $urandom & 32'hFFFF_FFFC};
    endcase
  endfunction

  // Monitor: every valid response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (inst_valid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got inst=%h err=%b want=no response (cycle %0d)", inst, inst_err, cyc);
      end else begin
        me = q.pop_front();
        if (inst !== me.inst || inst_err !== me.err || cyc != me.due) begin
          bad++;
          $display("FAIL response got inst=%h err=%b cyc=%0d want inst=%h err=%b cyc=%0d",
                   inst, inst_err, cyc, me.inst, me.err, me.due);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      total++;
      bad++;
      me = q.pop_front();
      $display("FAIL missing_valid got none want inst=%h err=%b at cyc=%0d", me.inst, me.err, me.due);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a request pending: everything must stay quiet.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, BASE, 1'b0, '0, 64'h0);
      chk("rst_inst", inst, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_err", inst_err, 0);
      chk("rst_busy", busy, 0);
    end

    // Preload image: words 0..15 and the last word.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 64'h0, 1'b1, DL'(i), (i == 0) ? 64'h0020_0093_0010_0093 : {$urandom, $urandom});
    step(1'b0, 1'b0, 64'h0, 1'b1, '1, {$urandom, $urandom});

    // Cold miss, then a back-to-back hit on the other half.
    fetch(BASE);
    idle(2);
    chk("cold_valid", inst_valid, 1);
    chk("cold_inst", inst, 64'h0010_0093);
    fetch(BASE + 64'd4);
    chk("hit_valid", inst_valid, 1);
    chk("hit_inst", inst, 64'h0020_0093);

    // Faults: misaligned, then below base (back-to-back).
    fetch(BASE + 64'd2);
    chk("flt_mis_err", inst_err, 1);
    chk("flt_mis_inst", inst, NOP);
    fetch(64'h7FFF_FFFC);
    chk("flt_low_valid", inst_valid, 1);
    chk("flt_low_err", inst_err, 1);
    chk("flt_low_inst", inst, NOP);
    idle(1);

    // Loader write invalidates the cached line.
    step(1'b0, 1'b0, 64'h0, 1'b1, '0, 64'h0000_0073_0000_0013);
    fetch(BASE + 64'd4);
    chk("coh_busy", busy, 1);
    idle(2);
    chk("coh_inst", inst, 64'h0000_0073);

    // Write to the hit line on the accept cycle forces a miss.
    step(1'b0, 1'b1, BASE, 1'b1, '0, 64'hAAAA_0001_BBBB_0002);
    chk("hitwr_busy", busy, 1);
    idle(2);
    chk("hitwr_inst", inst, 64'hBBBB_0002);

    // Write on the fill cycle to the filling index: new data, line stays valid.
    fetch(BASE + 64'd8);
    idle(1);
    step(1'b0, 1'b0, 64'h0, 1'b1, DL'(1), 64'h1111_2222_3333_4444);
    chk("wfirst_inst", inst, 64'h3333_4444);
    fetch(BASE + 64'd12);
    chk("wfirst_hit_busy", busy, 0);
    chk("wfirst_hit_inst", inst, 64'h1111_2222);

    // Reset in the second access cycle aborts the miss and empties the buffer.
    fetch(BASE + 64'd16);
    idle(1);
    step(1'b1, 1'b0, 64'h0, 1'b0, '0, 64'h0);
    chk("rstmiss_valid", inst_valid, 0);
    idle(2);
    chk("rstmiss_quiet", inst_valid, 0);
    fetch(BASE + 64'd16);
    chk("rstmiss_refetch_busy", busy, 1);
    idle(3);

    // Random traffic, including requests while busy and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic          r, e, w;
      logic [DL-1:0] la;
      r  = ($urandom_range(0, 255) == 0);
      e  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 4) == 0);
      la = ($urandom_range(0, 4) == 0) ? '1 : DL'($urandom_range(0, 15));
      step(r, e, rnd_addr(), w, la, {$urandom, $urandom});
    end

    idle(LAT + 3);
    chk("drain_outstanding", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
